// File: rtl/bf_pkg.sv
// Shared types, width helper and apodization weight constants for the delay-and-sum beamformer.
// Apodization weights are only used when BF_APODIZATION_EN is defined.
package bf_pkg;

  localparam int unsigned WEIGHT_W = 8;
  localparam logic [WEIGHT_W-1:0] WEIGHT_ONE = 8'd255;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } bf_state_e;

  function automatic int unsigned bf_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/beamformer_dsum_if.sv
// Sample, delay-table and result signals of the beamformer; the slave modport faces the DUT.
// BF_APODIZATION_EN adds the per-channel weight written alongside each delay.
interface beamformer_dsum_if #(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned NUM_MICS    = 25,
  parameter int unsigned DELAY_DEPTH = 32
);
  import bf_pkg::*;

  localparam int unsigned DW = bf_clog2(DELAY_DEPTH);
  localparam int unsigned CW = bf_clog2(NUM_MICS);
  localparam int unsigned OW = BIT_WIDTH + CW;

  logic                          sample_valid;
  logic [NUM_MICS*BIT_WIDTH-1:0] pcm_data_in_packed;
  logic                          delay_wr_en;
  logic [CW-1:0]                 delay_wr_idx;
  logic [DW-1:0]                 delay_wr_val;
`ifdef BF_APODIZATION_EN
  logic [WEIGHT_W-1:0]           delay_wr_weight;
`endif
  logic                          busy;
  logic                          out_valid;
  logic signed [OW-1:0]          delay_sum_data_out;
  logic                          overrun;

`ifdef BF_APODIZATION_EN
  modport master (
    output sample_valid, pcm_data_in_packed, delay_wr_en, delay_wr_idx, delay_wr_val,
    output delay_wr_weight,
    input  busy, out_valid, delay_sum_data_out, overrun
  );
  modport slave (
    input  sample_valid, pcm_data_in_packed, delay_wr_en, delay_wr_idx, delay_wr_val,
    input  delay_wr_weight,
    output busy, out_valid, delay_sum_data_out, overrun
  );
`else
  modport master (
    output sample_valid, pcm_data_in_packed, delay_wr_en, delay_wr_idx, delay_wr_val,
    input  busy, out_valid, delay_sum_data_out, overrun
  );
  modport slave (
    input  sample_valid, pcm_data_in_packed, delay_wr_en, delay_wr_idx, delay_wr_val,
    output busy, out_valid, delay_sum_data_out, overrun
  );
`endif

endinterface

// File: rtl/bf_delay_ram.sv
// Circular sample history: one wide write of every channel per frame, one registered
// single-channel read per cycle. Contents are not reset; the frame fill count masks stale data.
module bf_delay_ram
  import bf_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned NUM_MICS    = 25,
  parameter int unsigned DELAY_DEPTH = 32
) (
  input  logic                                 clk,
  input  logic                                 i_wr_en,
  input  logic [bf_clog2(DELAY_DEPTH)-1:0]     i_wr_addr,
  input  logic [NUM_MICS*BIT_WIDTH-1:0]        i_wr_data,
  input  logic [bf_clog2(DELAY_DEPTH)-1:0]     i_rd_addr,
  input  logic [bf_clog2(NUM_MICS)-1:0]        i_rd_ch,
  output logic signed [BIT_WIDTH-1:0]          o_rd_data
);

  logic [NUM_MICS*BIT_WIDTH-1:0] r_mem [DELAY_DEPTH];
  logic [NUM_MICS*BIT_WIDTH-1:0] w_word;
  logic signed [BIT_WIDTH-1:0]   r_rd_data;

  assign w_word    = r_mem[i_rd_addr];
  assign o_rd_data = r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= w_word[i_rd_ch*BIT_WIDTH +: BIT_WIDTH];
  end

endmodule

// File: rtl/beamformer_dsum.sv
// Delay-and-sum beamformer: one channel tap per cycle into a full-precision accumulator.
// BF_APODIZATION_EN adds a Q0.8 weight per channel (255 passes the tap unscaled).
module beamformer_dsum
  import bf_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned NUM_MICS    = 25,
  parameter int unsigned DELAY_DEPTH = 32
) (
  input logic              clk,
  input logic              rst,
  beamformer_dsum_if.slave bus
);

  localparam int unsigned DW = bf_clog2(DELAY_DEPTH);
  localparam int unsigned CW = bf_clog2(NUM_MICS);
  localparam int unsigned OW = BIT_WIDTH + CW;
  localparam logic [CW-1:0] LastCh  = CW'(NUM_MICS - 1);
  localparam logic [DW:0]   FillMax = (DW + 1)'(DELAY_DEPTH);

  bf_state_e            r_state;
  logic [DW-1:0]        r_wr_ptr;
  logic [DW:0]          r_fill;
  logic [CW-1:0]        r_ch;
  logic [DW-1:0]        r_shd_dly [NUM_MICS];
  logic [DW-1:0]        r_act_dly [NUM_MICS];
  logic signed [OW-1:0] r_acc;
  logic signed [OW-1:0] r_dout;
  logic                 r_tap_en;
  logic                 r_out_valid;
  logic                 r_overrun;

  logic                        w_start;
  logic                        w_wr_ok;
  logic [DW-1:0]               w_ch_dly;
  logic [DW-1:0]               w_rd_addr;
  logic                        w_tap_en;
  logic signed [BIT_WIDTH-1:0] w_rd_data;
  logic signed [OW-1:0]        w_tap;

`ifdef BF_APODIZATION_EN
  localparam int unsigned PW = BIT_WIDTH + WEIGHT_W + 1;
  logic [WEIGHT_W-1:0] r_shd_wt [NUM_MICS];
  logic [WEIGHT_W-1:0] r_act_wt [NUM_MICS];
  logic [WEIGHT_W-1:0] r_tap_wt;
  logic signed [PW-1:0] w_prod;
`endif

  assign w_start   = (r_state == StIdle) && bus.sample_valid;
  assign w_wr_ok   = bus.delay_wr_en && ({1'b0, bus.delay_wr_idx} < (CW + 1)'(NUM_MICS));
  assign w_ch_dly  = r_act_dly[r_ch];
  assign w_rd_addr = r_wr_ptr - w_ch_dly;
  // A channel only contributes once its delayed sample has actually been written.
  assign w_tap_en  = r_fill > {1'b0, w_ch_dly};

  always_comb begin
    w_tap = '0;
`ifdef BF_APODIZATION_EN
    w_prod = PW'(w_rd_data) * $signed(PW'(r_tap_wt));
    if (r_tap_en) begin
      if (r_tap_wt == WEIGHT_ONE) w_tap = OW'(w_rd_data);
      else                        w_tap = OW'(w_prod >>> WEIGHT_W);
    end
`else
    if (r_tap_en) w_tap = OW'(w_rd_data);
`endif
  end

  bf_delay_ram #(
    .BIT_WIDTH  (BIT_WIDTH),
    .NUM_MICS   (NUM_MICS),
    .DELAY_DEPTH(DELAY_DEPTH)
  ) u_ram (
    .clk      (clk),
    .i_wr_en  (w_start),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(bus.pcm_data_in_packed),
    .i_rd_addr(w_rd_addr),
    .i_rd_ch  (r_ch),
    .o_rd_data(w_rd_data)
  );

  // Read data lags the issuing cycle by one, so each ACCUM cycle adds the previous channel
  // and DONE folds in the last one while registering the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_ch        <= '0;
      r_acc       <= '0;
      r_dout      <= '0;
      r_tap_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < NUM_MICS; i++) begin
        r_shd_dly[i] <= '0;
        r_act_dly[i] <= '0;
`ifdef BF_APODIZATION_EN
        r_shd_wt[i] <= WEIGHT_ONE;
        r_act_wt[i] <= WEIGHT_ONE;
`endif
      end
`ifdef BF_APODIZATION_EN
      r_tap_wt <= WEIGHT_ONE;
`endif
    end else begin
      r_out_valid <= 1'b0;
      if (w_wr_ok) begin
        r_shd_dly[bus.delay_wr_idx] <= bus.delay_wr_val;
`ifdef BF_APODIZATION_EN
        r_shd_wt[bus.delay_wr_idx] <= bus.delay_wr_weight;
`endif
      end
      if ((r_state != StIdle) && bus.sample_valid) r_overrun <= 1'b1;
      case (r_state)
        StIdle: begin
          if (bus.sample_valid) begin
            r_act_dly <= r_shd_dly;
`ifdef BF_APODIZATION_EN
            r_act_wt  <= r_shd_wt;
`endif
            r_acc    <= '0;
            r_ch     <= '0;
            r_tap_en <= 1'b0;
            if (r_fill != FillMax) r_fill <= r_fill + 1'b1;
            r_state  <= StAccum;
          end
        end
        StAccum: begin
          r_acc    <= r_acc + w_tap;
          r_tap_en <= w_tap_en;
`ifdef BF_APODIZATION_EN
          r_tap_wt <= r_act_wt[r_ch];
`endif
          if (r_ch == LastCh) r_state <= StDone;
          else                r_ch    <= r_ch + 1'b1;
        end
        StDone: begin
          r_dout      <= r_acc + w_tap;
          r_out_valid <= 1'b1;
          r_wr_ptr    <= r_wr_ptr + 1'b1;
          r_tap_en    <= 1'b0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy               = (r_state != StIdle);
  assign bus.out_valid          = r_out_valid;
  assign bus.delay_sum_data_out = r_dout;
  assign bus.overrun            = r_overrun;

endmodule

// File: tb/tb_beamformer_dsum.sv
// Scoreboard bench for beamformer_dsum: a 4-mic and a 25-mic instance, directed frames.
// Weighted-tap cases run only when BF_APODIZATION_EN is defined.
module tb_beamformer_dsum;

  localparam int unsigned BW = 8;
  localparam int unsigned NA = 4;
  localparam int unsigned NB = 25;
  localparam int unsigned DD = 32;

  typedef struct {
    longint value;
    longint due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  longint      cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
`ifdef BF_APODIZATION_EN
  logic [7:0]  cur_wt = 8'd255;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  beamformer_dsum_if #(.BIT_WIDTH(BW), .NUM_MICS(NA), .DELAY_DEPTH(DD)) bus_a ();
  beamformer_dsum_if #(.BIT_WIDTH(BW), .NUM_MICS(NB), .DELAY_DEPTH(DD)) bus_b ();

  beamformer_dsum #(.BIT_WIDTH(BW), .NUM_MICS(NA), .DELAY_DEPTH(DD)) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  beamformer_dsum #(.BIT_WIDTH(BW), .NUM_MICS(NB), .DELAY_DEPTH(DD)) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus_a.out_valid) begin
      if (q_a.size() == 0) check("a_spurious_out_valid", 1, 0);
      else begin
        e = q_a.pop_front();
        check("a_sum", longint'(bus_a.delay_sum_data_out), e.value);
        check("a_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_b.out_valid) begin
      if (q_b.size() == 0) check("b_spurious_out_valid", 1, 0);
      else begin
        e = q_b.pop_front();
        check("b_sum", longint'(bus_b.delay_sum_data_out), e.value);
        check("b_latency", cyc, e.due);
      end
    end
  end

  task automatic frame_a(input int s0, input int s1, input int s2, input int s3,
                         input longint exp_sum, input bit push = 1'b1);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(s0);
    b1 = 8'(s1);
    b2 = 8'(s2);
    b3 = 8'(s3);
    @(negedge clk);
    bus_a.pcm_data_in_packed = {b3, b2, b1, b0};
    bus_a.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_a.sample_valid = 1'b0;
    if (push) q_a.push_back('{value: exp_sum, due: cyc + NA + 1});
  endtask

  task automatic frame_b(input int s, input longint exp_sum);
    logic [7:0] b;
    b = 8'(s);
    @(negedge clk);
    bus_b.pcm_data_in_packed = {NB{b}};
    bus_b.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_b.sample_valid = 1'b0;
    q_b.push_back('{value: exp_sum, due: cyc + NB + 1});
  endtask

  task automatic drain(input bit use_b);
    string nm;
    nm = use_b ? "b_drain" : "a_drain";
    for (int i = 0; i < 200; i++) begin
      if ((use_b ? q_b.size() : q_a.size()) == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    check(nm, use_b ? q_b.size() : q_a.size(), 0);
  endtask

  task automatic wr_dly_a(input int idx, input int val);
    @(negedge clk);
    bus_a.delay_wr_en  = 1'b1;
    bus_a.delay_wr_idx = 2'(idx);
    bus_a.delay_wr_val = 5'(val);
`ifdef BF_APODIZATION_EN
    bus_a.delay_wr_weight = cur_wt;
`endif
    @(posedge clk);
    #1;
    bus_a.delay_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.sample_valid       = 1'b0;
    bus_a.pcm_data_in_packed = '0;
    bus_a.delay_wr_en        = 1'b0;
    bus_a.delay_wr_idx       = '0;
    bus_a.delay_wr_val       = '0;
    bus_b.sample_valid       = 1'b0;
    bus_b.pcm_data_in_packed = '0;
    bus_b.delay_wr_en        = 1'b0;
    bus_b.delay_wr_idx       = '0;
    bus_b.delay_wr_val       = '0;
`ifdef BF_APODIZATION_EN
    bus_a.delay_wr_weight = 8'd255;
    bus_b.delay_wr_weight = 8'd255;
`endif
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", bus_a.busy, 0);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_overrun", bus_a.overrun, 0);
    check("rst_dout", longint'(bus_a.delay_sum_data_out), 0);
    check("rst_b_dout", longint'(bus_b.delay_sum_data_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Unity sums, zero delays
    frame_a(10, 10, 10, 10, 40);
    check("busy_in_frame", bus_a.busy, 1);
    drain(1'b0);
    check("busy_after_frame", bus_a.busy, 0);
    frame_a(1, -2, 3, -4, -2);
    drain(1'b0);
    frame_a(127, 127, 127, 127, 508);
    drain(1'b0);
    frame_a(-128, -128, -128, -128, -512);
    drain(1'b0);
    frame_b(-128, -3200);
    drain(1'b1);
    frame_b(127, 3175);
    drain(1'b1);

    // Delay 2 on ch0: first nonzero tap on the third frame
    do_reset();
    wr_dly_a(0, 2);
    frame_a(1, 0, 0, 0, 0);
    drain(1'b0);
    frame_a(2, 0, 0, 0, 0);
    drain(1'b0);
    frame_a(3, 0, 0, 0, 1);
    drain(1'b0);

    // Delay write coincident with frame start only takes effect next frame
    do_reset();
    frame_a(5, 5, 5, 5, 20);
    drain(1'b0);
    @(negedge clk);
    bus_a.pcm_data_in_packed = {4{8'd7}};
    bus_a.sample_valid = 1'b1;
    bus_a.delay_wr_en  = 1'b1;
    bus_a.delay_wr_idx = 2'd0;
    bus_a.delay_wr_val = 5'd1;
    @(posedge clk);
    #1;
    bus_a.sample_valid = 1'b0;
    bus_a.delay_wr_en  = 1'b0;
    q_a.push_back('{value: 28, due: cyc + NA + 1});
    drain(1'b0);
    frame_a(9, 9, 9, 9, 34);
    drain(1'b0);

    // sample_valid while busy is dropped and flagged
    do_reset();
    frame_a(3, 3, 3, 3, 12);
    @(posedge clk);
    @(negedge clk);
    bus_a.pcm_data_in_packed = {4{8'd100}};
    bus_a.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_a.sample_valid = 1'b0;
    drain(1'b0);
    check("overrun_set", bus_a.overrun, 1);
    wr_dly_a(0, 1);
    frame_a(4, 4, 4, 4, 15);
    drain(1'b0);
    check("overrun_sticky", bus_a.overrun, 1);

    // Reset during ACCUM aborts the frame
    frame_a(20, 20, 20, 20, 0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", bus_a.busy, 0);
    check("abort_out_valid", bus_a.out_valid, 0);
    check("abort_overrun", bus_a.overrun, 0);
    check("abort_dout", longint'(bus_a.delay_sum_data_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    check("abort_dout_held", longint'(bus_a.delay_sum_data_out), 0);

    // Delay 31 across the write-pointer wrap
    do_reset();
    wr_dly_a(0, 31);
    for (int k = 1; k <= 35; k++) begin
      frame_a(k, 0, 0, 0, (k >= 32) ? longint'(k - 31) : 64'sd0);
      drain(1'b0);
    end

`ifdef BF_APODIZATION_EN
    do_reset();
    cur_wt = 8'd128;
    wr_dly_a(0, 0);
    cur_wt = 8'd255;
    wr_dly_a(1, 0);
    cur_wt = 8'd0;
    wr_dly_a(2, 0);
    cur_wt = 8'd64;
    wr_dly_a(3, 0);
    frame_a(100, 100, 100, 100, 175);
    drain(1'b0);
    frame_a(-100, -100, -100, -100, -175);
    drain(1'b0);
    cur_wt = 8'd255;
`endif

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
